// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcode field width and command opcodes shared by the SPI RAM burst block
package spi_ram_pkg;

    localparam int OPC_W = 2;

    typedef enum logic [OPC_W-1:0] {
        OP_WRITE_ADD  = 2'b00,
        OP_WRITE_DATA = 2'b01,
        OP_READ_ADD   = 2'b10,
        OP_READ_DATA  = 2'b11
    } opcode_e;

endpackage

// File: rtl/spi_ram_burst_if.sv
// rtl/spi_ram_burst_if.sv - command in / read data out bundle for spi_ram_burst
interface spi_ram_burst_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              err;

    modport master (output din, rx_valid, input dout, tx_valid, err);
    modport slave  (input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - simple dual-port RAM, synchronous write, registered synchronous read
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // Array kept out of the reset domain so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - SPI-style command decoder in front of a word RAM
// SPI_RAM_AUTOINC_EN: accepted data commands post-increment their address, wrapping at MEM_DEPTH-1
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_burst_if.slave bus
);
    localparam int LIM_W = DATA_W + 1;
    localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(MEM_DEPTH);
`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
`endif

    opcode_e           opcode;
    logic [DATA_W-1:0] payload;
    logic              addr_ok;

    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q, rd_addr_d, rd_addr_q;
    logic              wr_armed_d, wr_armed_q, rd_armed_d, rd_armed_q;
    logic              rd_pend_d, rd_pend_q, err_pend_d, err_pend_q;
    logic [DATA_W-1:0] dout_d, dout_q;
    logic              tx_valid_d, tx_valid_q, err_d, err_q;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;

    assign opcode  = opcode_e'(bus.din[DATA_W+OPC_W-1:DATA_W]);
    assign payload = bus.din[DATA_W-1:0];
    assign addr_ok = ({1'b0, payload} < DEPTH_LIM);

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        rd_pend_d  = 1'b0;
        err_pend_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        // Output stage trails the RAM read register by one edge
        dout_d     = rd_pend_q ? mem_rdata : dout_q;
        tx_valid_d = rd_pend_q;
        err_d      = err_pend_q;
        if (bus.rx_valid) begin
            case (opcode)
                OP_WRITE_ADD: begin
                    if (addr_ok) begin
                        wr_addr_d  = payload[ADDR_W-1:0];
                        wr_armed_d = 1'b1;
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end
                OP_WRITE_DATA: begin
                    if (wr_armed_q) begin
                        mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
`endif
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end
                OP_READ_ADD: begin
                    if (addr_ok) begin
                        rd_addr_d  = payload[ADDR_W-1:0];
                        rd_armed_d = 1'b1;
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end
                OP_READ_DATA: begin
                    if (rd_armed_q) begin
                        mem_re    = 1'b1;
                        rd_pend_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
`endif
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_armed_q <= 1'b0;
            rd_armed_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            err_pend_q <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_armed_q <= wr_armed_d;
            rd_armed_q <= rd_armed_d;
            rd_pend_q  <= rd_pend_d;
            err_pend_q <= err_pend_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_addr_q),
        .wdata (payload),
        .re    (mem_re),
        .raddr (rd_addr_q),
        .rdata (mem_rdata)
    );

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb/tb_spi_ram_burst.sv - vector table plus scoreboard bench for spi_ram_burst (MEM_DEPTH=200)
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    typedef struct packed {
        logic       tx;
        logic [7:0] dout;
        logic       err;
    } exp_t;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [7:0] pay;
        exp_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_ram_burst_if #(.DATA_W(8)) bus ();

    spi_ram_burst #(
        .DATA_W    (8),
        .MEM_DEPTH (200),
        .ADDR_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[23];
    logic [7:0] b0, b1, b2;

    function automatic vec_t mk(logic v, logic [1:0] op, logic [7:0] pay,
                                logic tx, logic [7:0] d, logic er);
        vec_t r;
        r.v   = v;
        r.op  = op;
        r.pay = pay;
        r.exp = {tx, d, er};
        return r;
    endfunction

    function automatic exp_t ex(logic tx, logic [7:0] d, logic er);
        return {tx, d, er};
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = {bus.tx_valid, bus.dout, bus.err};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got tx=%0b dout=%02h err=%0b, want tx=%0b dout=%02h err=%0b",
                     name, a.tx, a.dout, a.err, e.tx, e.dout, e.err);
        end
    endtask

    task automatic check_sb(input string name);
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no expectation queued, got tx=%0b", name, bus.tx_valid);
        end else begin
            compare(name, sb_q.pop_front());
        end
    endtask

    task automatic step(input string name, input logic v, input logic [1:0] op,
                        input logic [7:0] pay, input exp_t e);
        @(negedge clk);
        bus.rx_valid = v;
        bus.din      = {op, pay};
        @(posedge clk);
        #1;
        check_sb(name);
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check_sb(name);
    endtask

    initial begin
        tbl[0]  = mk(1, OP_READ_DATA,  8'h00, 0, 8'h00, 1);
        tbl[1]  = mk(1, OP_WRITE_ADD,  8'h10, 0, 8'h00, 0);
        tbl[2]  = mk(1, OP_WRITE_DATA, 8'hA5, 0, 8'h00, 0);
        tbl[3]  = mk(1, OP_READ_ADD,   8'h10, 0, 8'h00, 0);
        tbl[4]  = mk(1, OP_READ_DATA,  8'h00, 1, 8'hA5, 0);
        tbl[5]  = mk(0, OP_READ_DATA,  8'h00, 0, 8'hA5, 0);
        tbl[6]  = mk(1, OP_READ_ADD,   8'h05, 0, 8'hA5, 0);
        tbl[7]  = mk(1, OP_WRITE_ADD,  8'h05, 0, 8'hA5, 0);
        tbl[8]  = mk(1, OP_WRITE_DATA, 8'h3C, 0, 8'hA5, 0);
        tbl[9]  = mk(1, OP_READ_DATA,  8'h00, 1, 8'h3C, 0);
        tbl[10] = mk(1, OP_READ_ADD,   8'h05, 0, 8'h3C, 0);
        tbl[11] = mk(1, OP_READ_ADD,   8'hC8, 0, 8'h3C, 1);
        tbl[12] = mk(1, OP_READ_DATA,  8'h00, 1, 8'h3C, 0);
        tbl[13] = mk(1, OP_WRITE_ADD,  8'hC8, 0, 8'h3C, 1);
        tbl[14] = mk(1, OP_WRITE_ADD,  8'hC7, 0, 8'h3C, 0);
        tbl[15] = mk(1, OP_WRITE_DATA, 8'h77, 0, 8'h3C, 0);
        tbl[16] = mk(1, OP_READ_ADD,   8'hC7, 0, 8'h3C, 0);
        tbl[17] = mk(1, OP_READ_DATA,  8'h00, 1, 8'h77, 0);
        tbl[18] = mk(1, OP_READ_ADD,   8'h10, 0, 8'h77, 0);
        tbl[19] = mk(1, OP_READ_DATA,  8'h00, 1, 8'hA5, 0);
        tbl[20] = mk(0, OP_WRITE_DATA, 8'hFF, 0, 8'hA5, 0);
        tbl[21] = mk(1, OP_READ_ADD,   8'hC7, 0, 8'hA5, 0);
        tbl[22] = mk(1, OP_READ_DATA,  8'h00, 1, 8'h77, 0);

        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.din      = '0;
        repeat (3) @(posedge clk);
        #1;
        compare("reset_state", ex(0, 8'h00, 0));
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(ex(0, 8'h00, 0));

        for (int i = 0; i < 23; i++) begin
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].op, tbl[i].pay, tbl[i].exp);
        end

        // Three writes then three back-to-back reads
`ifdef SPI_RAM_AUTOINC_EN
        b0 = 8'h01; b1 = 8'h02; b2 = 8'h03;
`else
        b0 = 8'h03; b1 = 8'h03; b2 = 8'h03;
`endif
        step("b2b_wa",  1, OP_WRITE_ADD,  8'h20, ex(0, 8'h77, 0));
        step("b2b_wd1", 1, OP_WRITE_DATA, 8'h01, ex(0, 8'h77, 0));
        step("b2b_wd2", 1, OP_WRITE_DATA, 8'h02, ex(0, 8'h77, 0));
        step("b2b_wd3", 1, OP_WRITE_DATA, 8'h03, ex(0, 8'h77, 0));
        step("b2b_ra",  1, OP_READ_ADD,   8'h20, ex(0, 8'h77, 0));
        step("b2b_rd1", 1, OP_READ_DATA,  8'h00, ex(1, b0, 0));
        step("b2b_rd2", 1, OP_READ_DATA,  8'h00, ex(1, b1, 0));
        step("b2b_rd3", 1, OP_READ_DATA,  8'h00, ex(1, b2, 0));
        step("b2b_idle", 0, OP_READ_DATA, 8'h00, ex(0, b2, 0));

`ifdef SPI_RAM_AUTOINC_EN
        step("wrap_wa",  1, OP_WRITE_ADD,  8'hC7, ex(0, b2, 0));
        step("wrap_wd1", 1, OP_WRITE_DATA, 8'h11, ex(0, b2, 0));
        step("wrap_wd2", 1, OP_WRITE_DATA, 8'h22, ex(0, b2, 0));
        step("wrap_ra",  1, OP_READ_ADD,   8'hC7, ex(0, b2, 0));
        step("wrap_rd1", 1, OP_READ_DATA,  8'h00, ex(1, 8'h11, 0));
        step("wrap_rd2", 1, OP_READ_DATA,  8'h00, ex(1, 8'h22, 0));
        step("wrap_idle", 0, OP_READ_DATA, 8'h00, ex(0, 8'h22, 0));
`endif

        // Reset lands while a READ_DATA is still in the pipeline
        step("inflight_ra", 1, OP_READ_ADD,  8'h10, ex(0, bus.dout, 0));
        step("inflight_rd", 1, OP_READ_DATA, 8'h00, ex(1, 8'hA5, 0));
        #2;
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        compare("inflight_in_reset", ex(0, 8'h00, 0));
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(ex(0, 8'h00, 0));
        step("post_rst_idle1", 0, OP_READ_DATA, 8'h00, ex(0, 8'h00, 0));
        step("post_rst_idle2", 0, OP_READ_DATA, 8'h00, ex(0, 8'h00, 0));
        step("post_rst_rd_unarmed", 1, OP_READ_DATA, 8'h00, ex(0, 8'h00, 1));
        step("keep_ra10", 1, OP_READ_ADD,  8'h10, ex(0, 8'h00, 0));
        step("keep_rd10", 1, OP_READ_DATA, 8'h00, ex(1, 8'hA5, 0));
        step("keep_ra05", 1, OP_READ_ADD,  8'h05, ex(0, 8'hA5, 0));
        step("keep_rd05", 1, OP_READ_DATA, 8'h00, ex(1, 8'h3C, 0));
        drain("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 Parameter DATA_W, default 8, data and payload width in bits.
REQ-002 Parameter MEM_DEPTH, default 256, number of memory words; range 2 to 2**DATA_W.
REQ-003 Parameter ADDR_W, default 8, address width; SHALL equal ceil(log2(MEM_DEPTH)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion and active-low.
REQ-006 din  input  DATA_W+2  command word: [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
REQ-007 rx_valid  input  1  din is qualified on this clock edge.
REQ-008 dout  output  DATA_W  read data.
REQ-009 tx_valid  output  1  single-cycle strobe qualifying dout.
REQ-010 err  output  1  single-cycle strobe flagging a rejected command.

Function
REQ-011 Opcodes SHALL be: 00 WRITE_ADD, 01 WRITE_DATA, 10 READ_ADD, 11 READ_DATA.
REQ-012 The block SHALL ignore din on any edge where rx_valid is low, and no state SHALL change on that edge.
REQ-013 WRITE_ADD SHALL load wr_addr from payload[ADDR_W-1:0] and set wr_armed.
REQ-014 WRITE_DATA with wr_armed set SHALL write the payload to mem[wr_addr] on the same edge.
REQ-015 READ_ADD SHALL load rd_addr from payload[ADDR_W-1:0] and set rd_armed.
REQ-016 READ_DATA with rd_armed set SHALL read mem[rd_addr] into a pipeline register.
REQ-017 For a READ_DATA sampled at edge N, dout SHALL be valid after edge N+1, and tx_valid SHALL be high for exactly that one cycle.
REQ-018 dout SHALL hold its last value when tx_valid is low.
REQ-019 WRITE_DATA without wr_armed, or READ_DATA without rd_armed, SHALL have no effect except an err pulse after edge N+1.
REQ-020 A WRITE_ADD or READ_ADD with a payload value of MEM_DEPTH or greater SHALL leave the address and armed flag unchanged and SHALL pulse err.
REQ-021 The write and read address/armed state machines SHALL be independent of each other; an interleaved write and read sequence SHALL be legal.
REQ-022 A READ_DATA at edge N+1 that follows a WRITE_DATA to the same address at edge N SHALL return the newly written data.
REQ-023 Back-to-back READ_DATA commands SHALL produce back-to-back tx_valid pulses with no bubble.

Reset
REQ-024 While rst_n is low, the following SHALL be 0: wr_addr, rd_addr, wr_armed, rd_armed, dout, tx_valid, err, and the read pipeline.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 A read in flight when reset asserts SHALL be discarded; no tx_valid pulse SHALL follow reset release.

Configuration
REQ-027 Macro SPI_RAM_AUTOINC_EN: when it is defined, each accepted WRITE_DATA SHALL increment wr_addr and each accepted READ_DATA SHALL increment rd_addr; the increment from MEM_DEPTH-1 SHALL wrap to 0.
REQ-028 When SPI_RAM_AUTOINC_EN is undefined, addresses SHALL change only on WRITE_ADD or READ_ADD, which is single-word behaviour.

Structure
REQ-029 Package spi_ram_pkg SHALL hold the opcode constants and the opcode field width (2).
REQ-030 Storage SHALL be a sub-module, spi_ram_mem: a simple dual-port memory with synchronous write, registered synchronous read, parametrised by DATA_W and MEM_DEPTH, and inferable as block RAM.

Verification
REQ-031 WRITE_ADD 0x10, WRITE_DATA 0xA5, READ_ADD 0x10, READ_DATA -> dout=0xA5 with a single tx_valid pulse one cycle after READ_DATA.
REQ-032 READ_DATA after reset, with no prior READ_ADD -> err pulse; tx_valid stays 0; dout=0.
REQ-033 With SPI_RAM_AUTOINC_EN defined and MEM_DEPTH=256: WRITE_ADD 0xFF, then WRITE_DATA 0x11 and 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22.
REQ-034 With MEM_DEPTH=200: READ_ADD 0xC8 -> err pulse; rd_addr unchanged.
REQ-035 With a READ_DATA issued and rst_n asserted on the next cycle -> no tx_valid pulse; after reset release, memory still holds its previously written values.
REQ-036 WRITE_DATA 0x3C to address 5, immediately followed by READ_DATA at address 5 -> dout=0x3C.
